// File: rtl/program_sequencer.sv
// Program counter sequencer with relative/absolute jumps and a LIFO return stack.
// Sticky overflow/underflow flags record CALL on a full stack and RET on an empty one.
module program_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  target,
  input  logic [ADDR_W-1:0]  offset,
  input  logic               clear_err,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  current_index,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HOLD   = 3'b101;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  cur_idx_q, cur_idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic               push_en_d;
  logic [ADDR_W-1:0]  push_data_d;

  logic               stack_full;
  logic               stack_empty;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  // Push writes slot [depth]; the top-of-stack lives at [depth-1].
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign depth_m1    = depth_q - DEPTH_W'(1);
  assign push_idx    = depth_q[IDX_W-1:0];
  assign pop_idx     = depth_m1[IDX_W-1:0];

  always_comb begin
    pc_d        = pc_q;
    cur_idx_d   = cur_idx_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q & ~clear_err;
    underflow_d = underflow_q & ~clear_err;
    push_en_d   = 1'b0;
    push_data_d = pc_q + ADDR_W'(1);

    // A fault raised on this edge overrides a simultaneous clear.
    if (enable) begin
      cur_idx_d = pc_q;
      case (op)
        OP_INC:    pc_d = pc_q + ADDR_W'(1);
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_CALL: begin
          if (stack_full) begin
            overflow_d = 1'b1;
          end else begin
            push_en_d = 1'b1;
            depth_d   = depth_q + DEPTH_W'(1);
            pc_d      = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            underflow_d = 1'b1;
          end else begin
            pc_d    = stack_q[pop_idx];
            depth_d = depth_m1;
          end
        end
        OP_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_ADDR;
      cur_idx_q   <= RESET_ADDR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cur_idx_q   <= cur_idx_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: depth alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push_en_d && !reset) begin
      stack_q[push_idx] <= push_data_d;
    end
  end

  assign pc            = pc_q;
  assign current_index = cur_idx_q;
  assign depth         = depth_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios followed by random ops,
// every cycle compared against a queue-based reference model.
module tb_program_sequencer;

  localparam int ADDR_W = 16;
  localparam int SD     = 8;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic              clear_err;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] current_index;
  logic [3:0]        depth;
  logic              overflow;
  logic              underflow;

  program_sequencer #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(SD),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .op           (op),
    .target       (target),
    .offset       (offset),
    .clear_err    (clear_err),
    .pc           (pc),
    .current_index(current_index),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_ci;
  logic [ADDR_W-1:0] m_stack[$];
  logic              m_ovf;
  logic              m_unf;
  logic [ADDR_W-1:0] exp_q[$];

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic rst, input logic en, input logic [2:0] o,
                             input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] off,
                             input logic clr);
    if (rst) begin
      m_pc = 16'h0000;
      m_ci = 16'h0000;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (en) begin
        m_ci = m_pc;
        case (o)
          3'd0: m_pc = m_pc + 16'd1;
          3'd1: m_pc = t;
          3'd2: m_pc = m_pc + off;
          3'd3: begin
            if (m_stack.size() < SD) begin
              m_stack.push_back(m_pc + 16'd1);
              m_pc = t;
            end else begin
              m_ovf = 1'b1;
            end
          end
          3'd4: begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else m_unf = 1'b1;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic en, input logic [2:0] o,
                      input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] off,
                      input logic clr);
    logic [ADDR_W-1:0] exp_pc;
    @(negedge clock);
    reset     = rst;
    enable    = en;
    op        = o;
    target    = t;
    offset    = off;
    clear_err = clr;
    model_apply(rst, en, o, t, off, clr);
    exp_q.push_back(m_pc);
    @(posedge clock);
    #1;
    exp_pc = exp_q.pop_front();
    check({tag, "_pc"},    32'(pc), 32'(exp_pc));
    check({tag, "_ci"},    32'(current_index), 32'(m_ci));
    check({tag, "_depth"}, 32'(depth), 32'(m_stack.size()));
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, "_unf"},   32'(underflow), 32'(m_unf));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    op        = 3'd0;
    target    = '0;
    offset    = '0;
    clear_err = 1'b0;
    m_pc  = '0;
    m_ci  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // reset state and simple INC with lagging current_index
    step("rst0", 1, 0, 3'd0, 0, 0, 0);
    check("rst0_pc_const", 32'(pc), 32'h0);
    step("inc1", 0, 1, 3'd0, 0, 0, 0);
    step("inc2", 0, 1, 3'd0, 0, 0, 0);
    step("inc3", 0, 1, 3'd0, 0, 0, 0);
    check("inc3_pc_const", 32'(pc), 32'h3);
    check("inc3_ci_const", 32'(current_index), 32'h2);

    // CALL / INC / INC / RET round trip
    step("jmp_ff", 0, 1, 3'd1, 16'h00FF, 0, 0);
    step("call1", 0, 1, 3'd3, 16'h1000, 0, 0);
    check("call1_depth_const", 32'(depth), 32'h1);
    step("cinc1", 0, 1, 3'd0, 0, 0, 0);
    step("cinc2", 0, 1, 3'd0, 0, 0, 0);
    step("ret1", 0, 1, 3'd4, 0, 0, 0);
    check("ret1_pc_const", 32'(pc), 32'h0100);

    // fill the stack, then overflow, then clear with enable low
    step("rst1", 1, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < SD; i++) step("fill", 0, 1, 3'd3, 16'(16'h0100 * (i + 1)), 0, 0);
    step("ovf", 0, 1, 3'd3, 16'h2222, 0, 0);
    check("ovf_pc_const", 32'(pc), 32'h0800);
    check("ovf_flag_const", 32'(overflow), 32'h1);
    step("ovf_hold", 0, 1, 3'd5, 0, 0, 0);
    step("ovf_clr", 0, 0, 3'd3, 16'h3333, 0, 1);
    check("ovf_clr_const", 32'(overflow), 32'h0);
    // drain the full stack to check LIFO order
    for (int i = 0; i < SD; i++) step("drain", 0, 1, 3'd4, 0, 0, 0);

    // underflow and new-fault-wins over clear_err
    step("rst2", 1, 0, 3'd0, 0, 0, 0);
    step("jmp_40", 0, 1, 3'd1, 16'h0040, 0, 0);
    step("unf", 0, 1, 3'd4, 0, 0, 0);
    step("unf_clr", 0, 1, 3'd4, 0, 0, 1);
    check("unf_clr_const", 32'(underflow), 32'h1);

    // wrap and branch arithmetic
    step("jmp_ffff", 0, 1, 3'd1, 16'hFFFF, 0, 0);
    step("wrap", 0, 1, 3'd0, 0, 0, 0);
    check("wrap_const", 32'(pc), 32'h0);
    step("jmp_5", 0, 1, 3'd1, 16'h0005, 0, 0);
    step("br_neg", 0, 1, 3'd2, 0, 16'hFFFB, 0);
    step("br_pos", 0, 1, 3'd2, 0, 16'h0003, 0);
    check("br_pos_const", 32'(pc), 32'h3);
    step("br_m1", 0, 1, 3'd2, 0, 16'hFFFF, 0);
    step("op6", 0, 1, 3'd6, 16'h7777, 0, 0);
    step("op7", 0, 1, 3'd7, 16'h7777, 0, 0);

    // enable low holds everything; reset mid call sequence
    for (int i = 0; i < 3; i++) step("dis", 0, 0, 3'd1, 16'h1234, 0, 0);
    for (int i = 0; i < 3; i++) step("c3", 0, 1, 3'd3, 16'(16'h0A00 + i), 0, 0);
    step("rst_pri", 1, 1, 3'd3, 16'h5555, 0, 1);
    check("rst_pri_depth_const", 32'(depth), 32'h0);
    step("post_rst", 0, 1, 3'd0, 0, 0, 0);

    // randomized traffic biased toward stack activity
    for (int i = 0; i < 600; i++) begin
      logic       r_rst;
      logic       r_en;
      logic [2:0] r_op;
      logic       r_clr;
      r_rst = ($urandom_range(0, 99) < 2);
      r_en  = ($urandom_range(0, 9) < 8);
      r_op  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 4));
      r_clr = ($urandom_range(0, 9) == 0);
      step("rnd", r_rst, r_en, r_op, 16'($urandom), 16'($urandom), r_clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
